// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch sequencer: reads 1-4 opcode-sized bytes from an 8-bit
// program memory, packs them MSB-first and strobes the instruction register once per fetch.
module fetch_seq #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       ir_raw,
  output logic [1:0]        ir_len,
  output logic              ir_we,
  output logic              busy,
  output logic              fetch_done
);

  typedef enum logic [1:0] {IDLE, BYTE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       ir_raw_q, ir_raw_d;
  logic [1:0]        ir_len_q, ir_len_d;
  logic [1:0]        cur_len;

  // The opcode byte's length field is needed in the same cycle it arrives.
  assign cur_len = (idx_q == 2'd0) ? mem_rdata[7:6] : len_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    idx_d    = idx_q;
    len_d    = len_q;
    asm_d    = asm_q;
    ir_raw_d = ir_raw_q;
    ir_len_d = ir_len_q;
    if (pc_load) begin
      state_d = IDLE;
      pc_d    = pc_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            state_d = BYTE;
            idx_d   = 2'd0;
            asm_d   = 32'h0;
          end
        end
        BYTE: begin
          if (mem_ack) begin
            case (idx_q)
              2'd0:    asm_d[31:24] = mem_rdata;
              2'd1:    asm_d[23:16] = mem_rdata;
              2'd2:    asm_d[15:8]  = mem_rdata;
              default: asm_d[7:0]   = mem_rdata;
            endcase
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (idx_q == 2'd0) len_d = mem_rdata[7:6];
            // Load the IR image on entry to WRITE so it is stable for the whole strobe.
            if (idx_q == cur_len) begin
              state_d  = WRITE;
              ir_raw_d = asm_d;
              ir_len_d = cur_len;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end
        WRITE:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      idx_q    <= 2'd0;
      len_q    <= 2'd0;
      asm_q    <= 32'h0;
      ir_raw_q <= 32'h0;
      ir_len_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      asm_q    <= asm_d;
      ir_raw_q <= ir_raw_d;
      ir_len_q <= ir_len_d;
    end
  end

  assign mem_req    = (state_q == BYTE);
  assign mem_addr   = pc_q;
  assign ir_raw     = ir_raw_q;
  assign ir_len     = ir_len_q;
  assign ir_we      = (state_q == WRITE);
  assign fetch_done = (state_q == WRITE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: behavioural byte memory with programmable wait states,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_seq;

  logic        clk, rst, fetch_req, pc_load, mem_ack, mem_req, ir_we, busy, fetch_done;
  logic [15:0] pc_in, mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] ir_raw;
  logic [1:0]  ir_len;

  logic [7:0]  mem [0:65535];
  int          wait_cycles, wcnt, we_cnt, req_cnt, passed, total, base_we, base_req;

  fetch_seq #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load), .pc_in(pc_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .ir_raw(ir_raw), .ir_len(ir_len), .ir_we(ir_we), .busy(busy), .fetch_done(fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responds after wait_cycles idle request cycles; an offered ack is consumed at the next edge.
  always @(negedge clk) begin
    if (mem_ack) wcnt = 0;
    if (mem_req && wcnt >= wait_cycles) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      if (mem_req) wcnt++;
    end
  end

  always @(posedge clk) begin
    if (ir_we)   we_cnt++;
    if (mem_req) req_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_pc(input logic [15:0] v);
    @(negedge clk); pc_load = 1'b1; pc_in = v;
    @(negedge clk); pc_load = 1'b0;
  endtask

  // Issue one fetch, wait (bounded) for the strobe, then check result and PC.
  task automatic do_fetch(input string tag, input logic [31:0] exp_raw,
                          input logic [1:0] exp_len, input logic [15:0] exp_pc);
    int seen;
    seen     = 0;
    base_we  = we_cnt;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ir_we) begin seen = 1; break; end
      @(negedge clk);
    end
    chk({tag, "_strobe_seen"}, seen, 1);
    chk({tag, "_ir_raw"}, ir_raw, exp_raw);
    chk({tag, "_ir_len"}, {30'd0, ir_len}, {30'd0, exp_len});
    chk({tag, "_done"}, {31'd0, fetch_done}, 32'd1);
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pc"}, {16'd0, mem_addr}, {16'd0, exp_pc});
    chk({tag, "_we_count"}, we_cnt - base_we, 1);
  endtask

  initial begin
    passed = 0; total = 0; we_cnt = 0; req_cnt = 0; wcnt = 0; wait_cycles = 0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pc", {16'd0, mem_addr}, 32'h0000FFFF);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_ir_we", {30'd0, ir_we, fetch_done}, 0);
    chk("rst_ir_raw", ir_raw, 0);
    chk("rst_ir_len", {30'd0, ir_len}, 0);

    // Wrap across 0xFFFF -> 0x0000 from the reset PC.
    mem[16'hFFFF] = 8'h47; mem[16'h0000] = 8'h99;
    do_fetch("wrap", 32'h47990000, 2'd1, 16'h0001);

    // One-byte instruction, cycle-exact latency.
    mem[16'h0000] = 8'h12;
    load_pc(16'h0000);
    base_we = we_cnt;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    chk("t1_byte_req", {31'd0, mem_req}, 1);
    chk("t1_byte_addr", {16'd0, mem_addr}, 0);
    chk("t1_byte_no_we", {31'd0, ir_we}, 0);
    @(negedge clk);
    chk("t1_we", {30'd0, ir_we, fetch_done}, 32'd3);
    chk("t1_ir_raw", ir_raw, 32'h12000000);
    chk("t1_ir_len", {30'd0, ir_len}, 0);
    @(negedge clk);
    chk("t1_idle", {30'd0, busy, ir_we}, 0);
    chk("t1_pc", {16'd0, mem_addr}, 32'h1);
    chk("t1_hold_raw", ir_raw, 32'h12000000);
    chk("t1_we_count", we_cnt - base_we, 1);

    // Four-byte instruction.
    mem[0] = 8'hC1; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC;
    load_pc(16'h0000);
    do_fetch("t2", 32'hC1AABBCC, 2'd3, 16'h0004);

    // Three-byte instruction with three wait states per byte.
    mem[0] = 8'h85; mem[1] = 8'h34; mem[2] = 8'h56;
    load_pc(16'h0000);
    wait_cycles = 3;
    base_req = req_cnt;
    do_fetch("t3", 32'h85345600, 2'd2, 16'h0003);
    chk("t3_req_cycles", req_cnt - base_req, 12);
    wait_cycles = 0;

    // pc_load aborts a 4-byte fetch during its second byte.
    mem[16'h0100] = 8'hC1; mem[16'h0101] = 8'h11; mem[16'h0102] = 8'h22; mem[16'h0103] = 8'h33;
    mem[16'h0200] = 8'h05;
    load_pc(16'h0100);
    base_we = we_cnt;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk);
    chk("t4_mid_addr", {16'd0, mem_addr}, 32'h0101);
    pc_load = 1'b1; pc_in = 16'h0200;
    @(negedge clk); pc_load = 1'b0;
    chk("t4_abort_idle", {31'd0, busy}, 0);
    chk("t4_abort_pc", {16'd0, mem_addr}, 32'h0200);
    repeat (2) @(negedge clk);
    chk("t4_abort_no_we", we_cnt - base_we, 0);
    chk("t4_raw_held", ir_raw, 32'h85345600);
    do_fetch("t4_next", 32'h05000000, 2'd0, 16'h0201);

    // Asynchronous reset mid-BYTE.
    mem[16'h0300] = 8'hC1;
    load_pc(16'h0300);
    wait_cycles = 3;
    base_we = we_cnt;
    @(negedge clk); fetch_req = 1'b1;
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk);
    chk("t6_in_byte", {31'd0, mem_req}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_mem_req", {31'd0, mem_req}, 0);
    chk("t6_pc", {16'd0, mem_addr}, 32'h0000FFFF);
    chk("t6_ir_raw", ir_raw, 0);
    chk("t6_ir_len", {30'd0, ir_len}, 0);
    @(negedge clk); rst = 1'b0;
    wait_cycles = 0;
    repeat (3) @(negedge clk);
    chk("t6_no_we", we_cnt - base_we, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
